// File: rtl/sigma_pkg.sv
// Shared constants and elaboration helpers for the sigma accumulator and detector top.
package sigma_pkg;

    localparam int unsigned CH_NUM_DEF   = 4;
    localparam int unsigned DW_DEF       = 16;
    localparam int unsigned AVG_LOG2_DEF = 2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sigma_add_stage.sv
// One registered adder-tree level: sums adjacent input pairs, one bit wider, with its valid bit.
module sigma_add_stage #(
    parameter int unsigned N_IN = 2,
    parameter int unsigned W    = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           in_valid,
    input  logic [N_IN*W-1:0]              in_data,
    output logic                           out_valid,
    output logic [(N_IN/2)*(W+1)-1:0]      out_data
);

    localparam int unsigned NO = N_IN / 2;
    localparam int unsigned WO = W + 1;

    logic [NO*WO-1:0] pair_sum;

    always_comb begin
        pair_sum = '0;
        for (int i = 0; i < NO; i++) begin
            pair_sum[i*WO +: WO] = WO'(in_data[2*i*W +: W]) + WO'(in_data[(2*i+1)*W +: W]);
        end
    end

    // Data only loads with a surviving valid so the tree output holds between frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid & ~clear;
            if (in_valid && !clear) begin
                out_data <= pair_sum;
            end
        end
    end

endmodule

// File: rtl/sigma_accum.sv
// Pipelined sum of CH_NUM unsigned channel results, with an optional 2^AVG_LOG2-frame average.
module sigma_accum
    import sigma_pkg::*;
#(
    parameter int unsigned CH_NUM   = CH_NUM_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF,
    localparam int unsigned LV      = clog2(CH_NUM),
    localparam int unsigned SW      = DW + LV,
    localparam int unsigned AW      = SW + AVG_LOG2,
    localparam int unsigned CW      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [CH_NUM*DW-1:0] in_data,
    input  logic                 clear,
    output logic                 sum_valid,
    output logic [SW-1:0]        sum_data,
    output logic                 avg_valid,
    output logic [SW-1:0]        avg_data,
    output logic [CW-1:0]        win_cnt
);

    localparam int unsigned WIN = 32'd1 << AVG_LOG2;

    for (genvar k = 0; k < LV; k++) begin : g_lvl
        localparam int unsigned NI = CH_NUM >> k;
        localparam int unsigned WI = DW + k;

        logic                       v_in;
        logic [NI*WI-1:0]           d_in;
        logic                       v_out;
        logic [(NI/2)*(WI+1)-1:0]   d_out;

        if (k == 0) begin : g_first
            assign v_in = in_valid;
            assign d_in = in_data;
        end else begin : g_next
            assign v_in = g_lvl[k-1].v_out;
            assign d_in = g_lvl[k-1].d_out;
        end

        sigma_add_stage #(
            .N_IN (NI),
            .W    (WI)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (clear),
            .in_valid  (v_in),
            .in_data   (d_in),
            .out_valid (v_out),
            .out_data  (d_out)
        );
    end

    assign sum_valid = g_lvl[LV-1].v_out;
    assign sum_data  = g_lvl[LV-1].d_out;

    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;
    logic          win_last;

    assign acc_sum  = acc + AW'(sum_data);
    assign win_last = (win_cnt == CW'(WIN - 1));

    // The closing sum goes straight into the average so back-to-back windows need no dead cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            win_cnt   <= '0;
            avg_valid <= 1'b0;
            avg_data  <= '0;
        end else begin
            avg_valid <= 1'b0;
            if (clear) begin
                acc     <= '0;
                win_cnt <= '0;
            end else if (sum_valid) begin
                if (win_last) begin
                    avg_valid <= 1'b1;
                    avg_data  <= SW'(acc_sum >> AVG_LOG2);
                    acc       <= '0;
                    win_cnt   <= '0;
                end else begin
                    acc     <= acc_sum;
                    win_cnt <= win_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sigma_accum.sv
// Directed self-checking bench for sigma_accum at CH_NUM=4, DW=16, AVG_LOG2=2.
module tb_sigma_accum;

    localparam int unsigned CH = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned L  = 2;
    localparam int unsigned SW = 18;
    localparam int unsigned CW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [CH*DW-1:0]  in_data;
    logic              clear;
    logic              sum_valid;
    logic [SW-1:0]     sum_data;
    logic              avg_valid;
    logic [SW-1:0]     avg_data;
    logic [CW-1:0]     win_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int avg_pulses = 0;
    logic [SW-1:0] last_avg = '0;

    always #5 clk = ~clk;

    sigma_accum #(
        .CH_NUM   (CH),
        .DW       (DW),
        .AVG_LOG2 (L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear     (clear),
        .sum_valid (sum_valid),
        .sum_data  (sum_data),
        .avg_valid (avg_valid),
        .avg_data  (avg_data),
        .win_cnt   (win_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (avg_valid === 1'b1) begin
            avg_pulses++;
            last_avg = avg_data;
        end
    endtask

    task automatic frame(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = {d, c, b, a};
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        clear    = 1'b0;
        tick();
        tick();
        check("rst_sum_valid", 64'(sum_valid), 64'd0);
        check("rst_avg_valid", 64'(avg_valid), 64'd0);
        check("rst_sum_data", 64'(sum_data), 64'd0);
        check("rst_avg_data", 64'(avg_data), 64'd0);
        check("rst_win_cnt", 64'(win_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single frame latency
        avg_pulses = 0;
        frame(16'd1, 16'd2, 16'd3, 16'd4);
        check("lat_t1_sum_valid", 64'(sum_valid), 64'd0);
        tick();
        check("lat_t2_sum_valid", 64'(sum_valid), 64'd1);
        check("lat_t2_sum_data", 64'(sum_data), 64'd10);
        tick();
        check("lat_t3_sum_valid", 64'(sum_valid), 64'd0);
        check("lat_hold_sum_data", 64'(sum_data), 64'd10);
        check("lat_win_cnt", 64'(win_cnt), 64'd1);
        check("lat_no_avg", 64'(avg_pulses), 64'd0);

        // Clear drops the partial window but keeps sum_data
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_win_cnt", 64'(win_cnt), 64'd0);
        check("clr_keep_sum", 64'(sum_data), 64'd10);

        // Full-scale frames
        avg_pulses = 0;
        frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        check("max_sum_data", 64'(sum_data), 64'h3FFFC);
        frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        idle(4);
        check("max_avg_pulses", 64'(avg_pulses), 64'd1);
        check("max_avg_data", 64'(last_avg), 64'h3FFFC);
        check("max_win_cnt", 64'(win_cnt), 64'd0);

        // Sums 10,20,30,41 then 4,4,4,4 back to back
        avg_pulses = 0;
        frame(16'd1, 16'd2, 16'd3, 16'd4);
        frame(16'd5, 16'd5, 16'd5, 16'd5);
        frame(16'd3, 16'd7, 16'd9, 16'd11);
        frame(16'd10, 16'd10, 16'd10, 16'd11);
        check("b2b_t4p1_avg_valid", 64'(avg_valid), 64'd0);
        frame(16'd1, 16'd1, 16'd1, 16'd1);
        check("b2b_t4p2_avg_valid", 64'(avg_valid), 64'd0);
        frame(16'd1, 16'd1, 16'd1, 16'd1);
        check("b2b_t4p3_avg_valid", 64'(avg_valid), 64'd1);
        check("b2b_avg_data", 64'(avg_data), 64'd25);
        check("b2b_wrap_win_cnt", 64'(win_cnt), 64'd0);
        frame(16'd1, 16'd1, 16'd1, 16'd1);
        check("b2b_w2_avg_valid", 64'(avg_valid), 64'd0);
        check("b2b_w2_win_cnt1", 64'(win_cnt), 64'd1);
        frame(16'd1, 16'd1, 16'd1, 16'd1);
        check("b2b_w2_win_cnt2", 64'(win_cnt), 64'd2);
        idle(1);
        check("b2b_w2_win_cnt3", 64'(win_cnt), 64'd3);
        idle(1);
        check("b2b_w2_avg_valid_end", 64'(avg_valid), 64'd1);
        check("b2b_w2_avg_data", 64'(avg_data), 64'd4);
        idle(2);
        check("b2b_hold_avg_data", 64'(avg_data), 64'd4);
        check("b2b_pulses", 64'(avg_pulses), 64'd2);

        // Clear coincident with the 4th frame
        avg_pulses = 0;
        frame(16'd2, 16'd2, 16'd2, 16'd2);
        frame(16'd2, 16'd2, 16'd2, 16'd2);
        frame(16'd2, 16'd2, 16'd2, 16'd2);
        clear = 1'b1;
        frame(16'd2, 16'd2, 16'd2, 16'd2);
        clear = 1'b0;
        check("cfr_sum_valid", 64'(sum_valid), 64'd0);
        check("cfr_win_cnt", 64'(win_cnt), 64'd0);
        idle(5);
        check("cfr_no_avg", 64'(avg_pulses), 64'd0);
        check("cfr_win_cnt_idle", 64'(win_cnt), 64'd0);
        check("cfr_keep_avg_data", 64'(avg_data), 64'd4);
        for (int i = 0; i < 4; i++) frame(16'd2, 16'd2, 16'd2, 16'd2);
        idle(4);
        check("cfr_fresh_pulses", 64'(avg_pulses), 64'd1);
        check("cfr_fresh_avg", 64'(last_avg), 64'd8);

        // Gapped frames: sums 4,8,12,16 -> average 10
        avg_pulses = 0;
        frame(16'd1, 16'd1, 16'd1, 16'd1);
        idle(5);
        check("gap_win_cnt1", 64'(win_cnt), 64'd1);
        frame(16'd2, 16'd2, 16'd2, 16'd2);
        idle(3);
        check("gap_win_cnt2", 64'(win_cnt), 64'd2);
        frame(16'd3, 16'd3, 16'd3, 16'd3);
        idle(2);
        check("gap_win_cnt3", 64'(win_cnt), 64'd3);
        check("gap_no_early_avg", 64'(avg_pulses), 64'd0);
        frame(16'd4, 16'd4, 16'd4, 16'd4);
        idle(3);
        check("gap_pulses", 64'(avg_pulses), 64'd1);
        check("gap_avg_data", 64'(last_avg), 64'd10);
        check("gap_win_cnt0", 64'(win_cnt), 64'd0);

        // Reset mid-window
        avg_pulses = 0;
        frame(16'd3, 16'd3, 16'd3, 16'd3);
        frame(16'd3, 16'd3, 16'd3, 16'd3);
        idle(2);
        check("mrst_pre_win_cnt", 64'(win_cnt), 64'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_sum_data", 64'(sum_data), 64'd0);
        check("mrst_avg_data", 64'(avg_data), 64'd0);
        check("mrst_win_cnt", 64'(win_cnt), 64'd0);
        check("mrst_sum_valid", 64'(sum_valid), 64'd0);
        check("mrst_avg_valid", 64'(avg_valid), 64'd0);
        for (int i = 0; i < 4; i++) frame(16'd3, 16'd3, 16'd3, 16'd3);
        idle(4);
        check("mrst_pulses", 64'(avg_pulses), 64'd1);
        check("mrst_avg_data_new", 64'(last_avg), 64'd12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sigma_accum.md
Name: sigma_accum

Overview:
- Parametrised successor to the fixed 4-channel sample summer.
- Sums CH_NUM unsigned DW-bit channel results through a pipelined adder tree with a valid qualifier.
- Optionally averages the channel sum over a window of 2^AVG_LOG2 frames.
- Sits between the per-channel delta-sigma result registers and the detection/threshold logic.

Parameters:
- CH_NUM, 4, number of input channels; power of two, 2..16.
- DW, 16, width of each channel result (unsigned).
- AVG_LOG2, 2, log2 of the averaging window in frames; 0..8; 0 means window = 1.
- Derived localparam LV = log2(CH_NUM): adder tree depth.
- Derived localparam SW = DW+LV: sum width.
- Derived localparam AW = SW+AVG_LOG2: accumulator width.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset; synchronous, active-low; one clock, all logic on rising edge of clk.
- in_valid, input, 1, in_data holds one frame this cycle.
- in_data, input, CH_NUM*DW, packed channels; channel i at bits [i*DW +: DW].
- clear, input, 1, synchronous flush of pipeline valids and averaging window.
- sum_valid, output, 1, one-cycle pulse; sum_data valid.
- sum_data, output, SW, registered sum of all channels of one frame.
- avg_valid, output, 1, one-cycle pulse at window completion.
- avg_data, output, SW, windowed average: accumulator >> AVG_LOG2, truncated.
- win_cnt, output, max(AVG_LOG2,1), frames accumulated in current window.

Behaviour:
- Reset (rst_n=0 at a clock edge): all tree stage registers, valid pipeline bits, accumulator, win_cnt, sum_data, avg_data cleared to 0; sum_valid=avg_valid=0. Asserting rst_n mid-window discards the partial window.
- Adder tree:
  - LV registered levels; level k adds adjacent pairs from level k-1 and is 1 bit wider.
  - Unsigned arithmetic, full precision; no overflow is possible.
  - Latency: in_valid at cycle t -> sum_valid and sum_data at cycle t+LV (t+2 for CH_NUM=4).
  - Fully pipelined: accepts one frame every cycle; no backpressure.
- Valid pipeline:
  - An LV-deep shift of in_valid runs alongside the data.
  - Data registers may load every cycle. sum_data holds its last valid value when sum_valid=0 (enable on the valid bit).
- Averager, driven by sum_valid:
  - On sum_valid, acc += sum_data and win_cnt increments.
  - When the 2^AVG_LOG2-th sum is added, the next cycle drives avg_valid=1 and avg_data=(acc+last sum)>>AVG_LOG2. In the same cycle, acc is set to 0 and win_cnt to 0.
  - Averaging latency: last frame in_valid at t -> avg_valid at t+LV+1.
  - AVG_LOG2=0: every sum_valid yields avg_valid one cycle later, with avg_data=sum_data; win_cnt stays 0.
  - avg_data holds between pulses.
  - Gaps in in_valid are allowed; the window counts valid frames, not cycles.
- clear:
  - All valid pipeline bits, acc and win_cnt go to 0 at the next edge; frames in flight are dropped; sum_valid and avg_valid are 0 the next cycle.
  - sum_data and avg_data keep their values.
  - clear has priority over a coincident in_valid and over a coincident window completion: no avg_valid is produced.
- win_cnt wraps 2^AVG_LOG2-1 -> 0 exactly on the completion cycle. Back-to-back windows run with no dead cycle.

Decomposition:
- Package sigma_pkg holds:
  - a clog2 constant function;
  - the default CH_NUM, DW and AVG_LOG2 constants shared with the detector top.
- Sub-module sigma_add_stage: one registered tree level, parameterised by input count and width, carrying its valid bit. Instantiated LV times by a generate loop.
- The averager stays inline.

Test Plan (CH_NUM=4, DW=16, AVG_LOG2=2):
- Reset then a single frame {1,2,3,4} with in_valid at t -> sum_valid at t+2 with sum_data=10; no avg_valid.
- A frame of all 0xFFFF -> sum_data=0x3FFFC, no wrap. A window of 4 such frames -> avg_data=0x3FFFC.
- Four back-to-back frames with sums 10,20,30,41 -> avg_valid at last t+3 with avg_data=25 (101>>2). A next window of sums 4,4,4,4 -> avg_data=4 with no dead cycle.
- 3 frames, then clear asserted with a coincident 4th frame -> no avg_valid; win_cnt=0. Four fresh frames of sum 8 -> avg_data=8.
- Frames separated by 1-5 idle cycles -> avg_valid only after the 4th valid frame; in-window win_cnt steps 1,2,3, then 0.
- rst_n=0 for 1 cycle mid-window, after 2 frames -> all outputs 0. The window restarts: four frames of sum 12 -> avg_data=12.
